dp_byte_ram_p: RTL and testbench

- Parametrised successor of the data-memory BRAM.
- True dual-port, synchronous read/write memory with byte-granular write enables.
  - Port A serves the CPU MEM stage.
  - Port B serves the debug module.
- Adds the following over the previous block:
  - configurable width, depth and read latency;
  - synchronous reset with a hardware zero-fill sweep;
  - deterministic same-address write arbitration;
  - address-error and collision status pulses.

---
 rtl/dp_byte_ram_p.sv | 166 ++++++++++++++++
 tb/tb_dp_byte_ram_p.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_byte_ram_p.sv
// dp_byte_ram_p: true dual-port synchronous RAM with byte write enables.
// Port A serves the CPU MEM stage, port B the debug module.
// Optional macro INIT_CLEAR_EN: when defined, reset starts a hardware
// zero-fill sweep of the whole array and init_done rises only after it ends.
// When undefined, contents survive rst and only output/status state resets.
module dp_byte_ram_p #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [29:0]             addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [29:0]             addrb,
  input  logic [DATA_WIDTH-1:0]   dinb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    init_done,
  output logic                    addr_err_a,
  output logic                    addr_err_b,
  output logic                    wr_collision
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

`ifdef INIT_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = READY;
`endif

  state_t                  state;
  state_t                  state_next;
  logic [DEPTH_LOG2-1:0]   sweep_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    ready;
  logic                    valid_a;
  logic                    valid_b;
  logic [DEPTH_LOG2-1:0]   idx_a;
  logic [DEPTH_LOG2-1:0]   idx_b;
  logic [NB-1:0]           we_a_eff;
  logic [NB-1:0]           we_b_eff;
  logic                    collide;
  logic                    err_a_next;
  logic                    err_b_next;
  logic [DATA_WIDTH-1:0]   rd_a;
  logic [DATA_WIDTH-1:0]   rd_b;

  // Address decode, effective write enables and status conditions
  always_comb begin
    ready      = (state == READY);
    valid_a    = ((addra >> DEPTH_LOG2) == 30'd0);
    valid_b    = ((addrb >> DEPTH_LOG2) == 30'd0);
    idx_a      = addra[DEPTH_LOG2-1:0];
    idx_b      = addrb[DEPTH_LOG2-1:0];
    we_a_eff   = (ready && valid_a) ? wea : '0;
    we_b_eff   = (ready && valid_b) ? web : '0;
    collide    = ready && valid_a && valid_b && (idx_a == idx_b) && (|(wea & web));
    err_a_next = ready && !valid_a && (|wea);
    err_b_next = ready && !valid_b && (|web);
  end

  // FSM state register and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      sweep_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) begin
        sweep_cnt <= sweep_cnt + 1'b1;
      end
    end
  end

  // Next-state: leave CLEAR once the last index is being written
  always_comb begin
    state_next = state;
    if ((state == CLEAR) && (sweep_cnt == '1)) begin
      state_next = READY;
    end
  end

  // Array writes: sweep zero-fill, else byte lanes with port A applied last
  // so that it wins lanes both ports enable on the same word
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef INIT_CLEAR_EN
      if (state == CLEAR) begin
        mem[sweep_cnt] <= '0;
      end
`endif
      for (int unsigned i = 0; i < NB; i++) begin
        if (we_b_eff[i]) begin
          mem[idx_b][8*i +: 8] <= dinb[8*i +: 8];
        end
      end
      for (int unsigned i = 0; i < NB; i++) begin
        if (we_a_eff[i]) begin
          mem[idx_a][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  // First read stage: read-first, zero for invalid address or while clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a <= '0;
      rd_b <= '0;
    end else begin
      rd_a <= (ready && valid_a) ? mem[idx_a] : '0;
      rd_b <= (ready && valid_b) ? mem[idx_b] : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] pipe_a;
      logic [DATA_WIDTH-1:0] pipe_b;

      // Extra output register stage
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_a <= '0;
          pipe_b <= '0;
        end else begin
          pipe_a <= rd_a;
          pipe_b <= rd_b;
        end
      end

      assign douta = pipe_a;
      assign doutb = pipe_b;
    end else begin : g_lat1
      assign douta = rd_a;
      assign doutb = rd_b;
    end
  endgenerate

  // Status registers: one-cycle pulses and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done    <= 1'b0;
      addr_err_a   <= 1'b0;
      addr_err_b   <= 1'b0;
      wr_collision <= 1'b0;
    end else begin
      init_done    <= (state_next == READY);
      addr_err_a   <= err_a_next;
      addr_err_b   <= err_b_next;
      wr_collision <= collide;
    end
  end

endmodule

// File: tb/tb_dp_byte_ram_p.sv
// Directed bench for dp_byte_ram_p: a small instance (16 words, latency 2)
// and a default-sized instance (4096 words, latency 1).
module tb_dp_byte_ram_p;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance: DEPTH_LOG2=4, READ_LATENCY=2
  logic        rst = 1'b1;
  logic [3:0]  wea = '0;
  logic [29:0] addra = '0;
  logic [31:0] dina = '0;
  logic [31:0] douta;
  logic [3:0]  web = '0;
  logic [29:0] addrb = '0;
  logic [31:0] dinb = '0;
  logic [31:0] doutb;
  logic        init_done, err_a, err_b, coll;

  // Default instance: DEPTH_LOG2=12, READ_LATENCY=1
  logic        x_rst = 1'b1;
  logic [3:0]  x_wea = '0;
  logic [29:0] x_addra = '0;
  logic [31:0] x_dina = '0;
  logic [31:0] x_douta;
  logic [3:0]  x_web = '0;
  logic [29:0] x_addrb = '0;
  logic [31:0] x_dinb = '0;
  logic [31:0] x_doutb;
  logic        x_init_done, x_err_a, x_err_b, x_coll;

  int total = 0;
  int bad   = 0;

  dp_byte_ram_p #(.DATA_WIDTH(32), .DEPTH_LOG2(4), .READ_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb),
    .init_done(init_done), .addr_err_a(err_a), .addr_err_b(err_b),
    .wr_collision(coll)
  );

  dp_byte_ram_p #(.DATA_WIDTH(32), .DEPTH_LOG2(12), .READ_LATENCY(1)) u_dut_x (
    .clk(clk), .rst(x_rst),
    .wea(x_wea), .addra(x_addra), .dina(x_dina), .douta(x_douta),
    .web(x_web), .addrb(x_addrb), .dinb(x_dinb), .doutb(x_doutb),
    .init_done(x_init_done), .addr_err_a(x_err_a), .addr_err_b(x_err_b),
    .wr_collision(x_coll)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Small instance: init_done low for 16 edges after release, then high;
  // a port A write to word 2 near the end of the sweep must be dropped
  task automatic check_sweep();
    for (int i = 1; i <= 16; i++) begin
      if (i == 15) begin
        addra = 30'd2; wea = 4'hF; dina = 32'hFFFF_FFFF;
      end
      if (i == 16) begin
        wea = 4'h0;
      end
      tick();
      check("sweep_init_done", {31'b0, init_done}, (i < 16) ? 32'd0 : 32'd1);
      if (i < 16) check("sweep_douta_zero", douta, 32'd0);
    end
  endtask

  task automatic read_a(input logic [29:0] addr, input logic [31:0] exp, input string tag);
    addra = addr; wea = 4'h0;
    tick();
    tick();
    check(tag, douta, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---- reset state ----
    tick();
    check("rst_douta", douta, 32'd0);
    check("rst_doutb", doutb, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_err_a", {31'b0, err_a}, 32'd0);
    check("rst_err_b", {31'b0, err_b}, 32'd0);
    check("rst_coll", {31'b0, coll}, 32'd0);
    rst = 1'b0;

`ifdef INIT_CLEAR_EN
    // ---- reset mid-sweep at index 9, then full 16-cycle sweep ----
    for (int i = 0; i < 9; i++) begin
      tick();
      check("pre_sweep_init_low", {31'b0, init_done}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_sweep();
`else
    tick();
    check("nosweep_init_done", {31'b0, init_done}, 32'd1);
    for (int w = 0; w < 16; w++) begin
      addra = 30'(w); wea = 4'hF; dina = 32'd0;
      tick();
    end
    wea = 4'h0;
`endif

    // ---- all words read back zero ----
    for (int w = 0; w < 16; w++) begin
      read_a(30'(w), 32'd0, "zero_word");
    end

    // ---- byte writes, latency 2, read-first ----
    addra = 30'd5; wea = 4'hF; dina = 32'hDEAD_BEEF;
    tick();
    wea = 4'b0101; dina = 32'h1122_3344;
    tick();
    wea = 4'h0;
    tick();
    check("bytewr_lat1_old", douta, 32'hDEAD_BEEF);
    tick();
    check("bytewr_merged", douta, 32'hDE22_BE44);

    // ---- same-address collision ----
    addra = 30'd7; addrb = 30'd7;
    wea = 4'b0011; dina = 32'hAAAA_AAAA;
    web = 4'b0110; dinb = 32'hBBBB_BBBB;
    tick();
    check("coll_pulse", {31'b0, coll}, 32'd1);
    wea = 4'h0; web = 4'h0;
    tick();
    check("coll_one_cycle", {31'b0, coll}, 32'd0);
    tick();
    check("coll_word_a", douta, 32'h00BB_AAAA);
    check("coll_word_b", doutb, 32'h00BB_AAAA);

    // ---- invalid address on port B ----
    addrb = 30'h10; web = 4'hF; dinb = 32'hFFFF_FFFF;
    tick();
    check("inv_err_b", {31'b0, err_b}, 32'd1);
    check("inv_err_a_quiet", {31'b0, err_a}, 32'd0);
    web = 4'h0;
    tick();
    check("inv_err_b_once", {31'b0, err_b}, 32'd0);
    check("inv_doutb_zero", doutb, 32'd0);
    addrb = 30'd0;
    tick();
    tick();
    check("inv_word0_kept", doutb, 32'd0);

    // ---- invalid address on port A ----
    addra = 30'h20; wea = 4'b0001; dina = 32'hFFFF_FFFF;
    tick();
    check("inv_err_a", {31'b0, err_a}, 32'd1);
    wea = 4'h0;
    tick();
    check("inv_err_a_once", {31'b0, err_a}, 32'd0);

    // ---- cross-port read-first ----
    addra = 30'd3; wea = 4'hF; dina = 32'h1234_5678;
    tick();
    wea = 4'h0;
    addrb = 30'd3; web = 4'hF; dinb = 32'hCAFE_F00D;
    tick();
    check("xport_no_coll", {31'b0, coll}, 32'd0);
    web = 4'h0;
    tick();
    check("xport_read_first", douta, 32'h1234_5678);
    tick();
    check("xport_new_data", douta, 32'hCAFE_F00D);

    // ---- reset mid-operation discards in-flight read ----
    addra = 30'd3;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_douta", douta, 32'd0);
    check("midrst_init_low", {31'b0, init_done}, 32'd0);
    rst = 1'b0;
`ifdef INIT_CLEAR_EN
    check_sweep();
    read_a(30'd3, 32'd0, "midrst_word3_cleared");
    read_a(30'd2, 32'd0, "clear_write_dropped");
`else
    tick();
    check("midrst_init_done", {31'b0, init_done}, 32'd1);
    read_a(30'd3, 32'hCAFE_F00D, "midrst_word3_kept");
`endif

    // ---- default instance: latency 1, 4096 words ----
    tick();
    check("x_rst_douta", x_douta, 32'd0);
    check("x_rst_init", {31'b0, x_init_done}, 32'd0);
    x_rst = 1'b0;
    n = 0;
    while (!x_init_done && n < 5000) begin
      tick();
      n++;
    end
`ifdef INIT_CLEAR_EN
    check("x_init_cycles", 32'(n), 32'd4096);
`else
    check("x_init_cycles", 32'(n), 32'd1);
`endif
    x_addra = 30'd0; x_wea = 4'hF; x_dina = 32'h0000_0055;
    tick();
    x_addra = 30'd100; x_dina = 32'hA5A5_A5A5;
    tick();
    x_wea = 4'h0;
    x_addrb = 30'd100;
    tick();
    check("x_lat1_read", x_doutb, 32'hA5A5_A5A5);
    x_addrb = 30'h1000; x_web = 4'hF; x_dinb = 32'hFFFF_FFFF;
    tick();
    check("x_inv_err_b", {31'b0, x_err_b}, 32'd1);
    check("x_inv_doutb", x_doutb, 32'd0);
    x_web = 4'h0; x_addrb = 30'd0;
    tick();
    check("x_inv_err_once", {31'b0, x_err_b}, 32'd0);
    check("x_word0_kept", x_doutb, 32'h0000_0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
